// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the 8x1024 memory core and its
// read-side streaming engine.
//
// Contents:
//   MEM_DEPTH, MEM_AW, MEM_DW  geometry of the memory core
//   rd_state_t                 state encoding for the read streamer FSM
package mem_pkg;

  localparam int MEM_DEPTH = 1024;
  localparam int MEM_AW    = 10;
  localparam int MEM_DW    = 8;

  // IDLE : waiting for a start command
  // RUN  : addresses still left to issue
  // DRAIN: every address issued, waiting for the last word to leave
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/mem_stream_rd_if.sv
// mem_stream_rd_if -- valid/ready byte stream from the read streamer toward
// display/output logic.
//
// Signals:
//   out_valid  producer has a word on out_data
//   out_ready  consumer accepts the word this cycle
//   out_data   stream data, DW bits
//
// Modports:
//   master  producer side (mem_stream_rd)
//   slave   consumer side
interface mem_stream_rd_if
  import mem_pkg::*;
#(
  parameter int DW = MEM_DW
);

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/rd_buf2.sv
// rd_buf2 -- 2-entry synchronous FIFO that absorbs the memory's read latency
// in front of the output stream.
//
// Ports:
//   clk        system clock, posedge
//   reset      synchronous, active-high; empties the FIFO and zeroes entries
//   push       write push_data at the tail
//   push_data  data to write
//   pop        remove the head entry
//   head_data  current head entry (meaningful while count != 0)
//   count      number of held entries, 0..2
//
// A push and pop in the same cycle leave count unchanged. A push into a
// full FIFO is accepted only together with a pop.
module rd_buf2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [1:0]    count
);

  logic [DW-1:0] entry [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  // When full, the slot being written is the one leaving through the head.
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      entry[0] <= '0;
      entry[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= 2'd0;
    end else begin
      if (do_push) begin
        entry[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_data = entry[rd_ptr];
  assign count     = cnt;

endmodule

// File: rtl/mem_stream_rd.sv
// mem_stream_rd -- read-side streaming engine for the synchronous memory core.
// On a start command it walks a contiguous wrap-around address range, absorbs
// the memory's 1-cycle read latency and delivers the bytes in order on a
// valid/ready stream. It never writes; mem_wr is tied low so the memory can
// be shared with a writer through an external mux.
//
// Ports:
//   clk        system clock, posedge
//   reset      synchronous, active-high; aborts any transfer without done
//   start      1-cycle command, sampled only while busy=0
//   base_addr  first address of the transfer
//   len        word count, 0..2**AW
//   busy       transfer in progress
//   done       1-cycle pulse after the last word is accepted, or for len=0
//   mem_addr   memory address
//   mem_wr     memory write enable, constant 0
//   mem_d_o    memory read data, valid the cycle after mem_addr is presented
//   strm       output stream (master modport)
module mem_stream_rd
  import mem_pkg::*;
#(
  parameter int DW = MEM_DW,
  parameter int AW = MEM_AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [AW:0]     len,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wr,
  input  logic [DW-1:0]   mem_d_o,
  mem_stream_rd_if.master strm
);

  rd_state_t     state;
  logic [AW:0]   remaining;
  logic          inflight;
  logic [1:0]    buf_count;
  logic [DW-1:0] head_data;
  logic          pop;
  logic          issue;
  logic [2:0]    occ;
  logic [2:0]    lim;

  assign mem_wr = 1'b0;

  assign strm.out_valid = (buf_count != 2'd0);
  assign strm.out_data  = head_data;
  assign pop            = strm.out_valid & strm.out_ready;

  // Words held plus the one in flight must stay below two once this cycle's
  // pop is credited; written as occ < 2 + pop to avoid an unsigned underflow.
  assign occ   = {1'b0, buf_count} + {2'b00, inflight};
  assign lim   = 3'd2 + {2'b00, pop};
  assign issue = (state == RUN) && (occ < lim);

  // The word read by last cycle's issue is on mem_d_o now.
  rd_buf2 #(
    .DW (DW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (mem_d_o),
    .pop       (pop),
    .head_data (head_data),
    .count     (buf_count)
  );

  // mem_addr always shows the next address to issue, so an issue cycle is the
  // cycle it is presented; after the final issue it holds that last address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;

      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              mem_addr  <= base_addr;
              remaining <= len;
              busy      <= 1'b1;
              state     <= RUN;
            end
          end
        end

        RUN: begin
          if (issue) begin
            remaining <= remaining - 1'b1;
            if (remaining == (AW+1)'(1)) begin
              state <= DRAIN;
            end else begin
              mem_addr <= mem_addr + 1'b1;
            end
          end
        end

        DRAIN: begin
          // The last word is the only one held and nothing is left in flight.
          if ((buf_count == 2'd1) && !inflight && pop) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_rd.sv
// tb_mem_stream_rd -- self-checking bench for mem_stream_rd.
// A behavioural memory feeds the DUT; every transfer's expected byte stream is
// built from the memory array and (base + k) mod depth, and compared against
// the words actually accepted on the stream.
module tb_mem_stream_rd;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_d_o;

  mem_stream_rd_if #(.DW(DW)) strm ();

  mem_stream_rd #(
    .DW (DW),
    .AW (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_d_o   (mem_d_o),
    .strm      (strm)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data for an address appears the following cycle.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) mem_d_o <= mem[mem_addr];

  int checks     = 0;
  int fails      = 0;
  int cyc        = 0;
  int done_cnt   = 0;
  int stall_err  = 0;
  int wr_err     = 0;
  int cnt_err    = 0;
  int valid_seen = 0;
  int ready_mode = 0;
  int rdy_phase  = 0;

  logic [DW-1:0] got_q   [$];
  logic [DW-1:0] exp_q   [$];
  int            got_cyc [$];
  logic [AW-1:0] addr_log[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  // Stream monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_wr !== 1'b0) wr_err++;
    if (dut.buf_count > 2'd2) cnt_err++;
    if (strm.out_valid === 1'b1) valid_seen++;
    if (done === 1'b1) done_cnt++;
    if (prev_stall && !((strm.out_valid === 1'b1) && (strm.out_data === prev_data))) stall_err++;
    prev_stall = (strm.out_valid === 1'b1) && (strm.out_ready === 1'b0) && !reset;
    prev_data  = strm.out_data;
    if ((strm.out_valid === 1'b1) && (strm.out_ready === 1'b1) && !reset) begin
      got_q.push_back(strm.out_data);
      got_cyc.push_back(cyc);
    end
    if ((busy === 1'b1) && ((addr_log.size() == 0) || (mem_addr != addr_log[$])))
      addr_log.push_back(mem_addr);
  end

  // Downstream ready: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
  initial begin
    strm.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          strm.out_ready = (rdy_phase == 0);
          rdy_phase = (rdy_phase + 1) % 3;
        end
        2:       strm.out_ready = 1'($urandom_range(0, 1));
        default: strm.out_ready = 1'b1;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int base, input int n);
    @(posedge clk);
    #1;
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    addr_log.delete();
    done_cnt   = 0;
    stall_err  = 0;
    valid_seen = 0;
    cnt_err    = 0;
    for (int k = 0; k < n; k++) exp_q.push_back(mem[(base + k) % DEPTH]);
    base_addr = AW'(base);
    len       = (AW+1)'(n);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitWords(input string tag, input int n, input int budget);
    int b = 0;
    while ((got_q.size() < n) && (b < budget)) begin
      @(negedge clk);
      b++;
    end
    checkOutput({tag, "_word_budget"}, 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic checkTransfer(input string tag);
    repeat (4) @(negedge clk);
    checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; (i < got_q.size()) && (i < exp_q.size()); i++)
      checkOutput($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
    checkOutput({tag, "_done_pulses"}, done_cnt, 1);
    checkOutput({tag, "_busy_after"}, busy, 0);
    checkOutput({tag, "_stall_stable"}, stall_err, 0);
    checkOutput({tag, "_mem_wr"}, wr_err, 0);
    checkOutput({tag, "_occupancy"}, cnt_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_valid", strm.out_valid, 0);
    checkOutput("rst_data", strm.out_data, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_wr", mem_wr, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] test 1: base=5 len=4, always ready");
    applyStimulus(5, 4);
    @(negedge clk);
    checkOutput("t1_busy_set", busy, 1);
    checkOutput("t1_valid_c1", strm.out_valid, 0);
    @(negedge clk);
    checkOutput("t1_valid_c2", strm.out_valid, 0);
    @(negedge clk);
    checkOutput("t1_first_valid", strm.out_valid, 1);
    checkOutput("t1_first_data", strm.out_data, 32'h05);
    waitWords("t1", 4, 50);
    checkTransfer("t1");
    if (got_cyc.size() == 4) checkOutput("t1_back_to_back", got_cyc[3] - got_cyc[0], 3);
    else checkOutput("t1_cycle_log", got_cyc.size(), 4);

    $display("[TB] test 2: wrap base=1022 len=4");
    applyStimulus(1022, 4);
    waitWords("t2", 4, 50);
    checkTransfer("t2");
    checkOutput("t2_addr_count", addr_log.size(), 4);
    for (int i = 0; (i < addr_log.size()) && (i < 4); i++)
      checkOutput($sformatf("t2_addr%0d", i), addr_log[i], (1022 + i) % DEPTH);

    $display("[TB] test 3: len=8 with ready pattern 1,0,0");
    rdy_phase  = 0;
    ready_mode = 1;
    applyStimulus(100, 8);
    waitWords("t3", 8, 120);
    checkTransfer("t3");
    ready_mode = 0;

    $display("[TB] test 4: len=0");
    applyStimulus(9, 0);
    @(negedge clk);
    checkOutput("t4_done_pulse", done, 1);
    checkOutput("t4_busy", busy, 0);
    @(negedge clk);
    checkOutput("t4_done_clear", done, 0);
    checkOutput("t4_busy_later", busy, 0);
    repeat (5) @(negedge clk);
    checkOutput("t4_no_valid", valid_seen, 0);
    checkOutput("t4_done_pulses", done_cnt, 1);

    $display("[TB] test 5: reset during a len=16 transfer");
    applyStimulus(200, 16);
    waitWords("t5", 3, 50);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("t5_valid_after_rst", strm.out_valid, 0);
    checkOutput("t5_busy_after_rst", busy, 0);
    repeat (20) @(negedge clk);
    checkOutput("t5_no_done", done_cnt, 0);
    checkOutput("t5_still_idle", busy, 0);
    applyStimulus(0, 2);
    waitWords("t5b", 2, 50);
    checkTransfer("t5b");

    $display("[TB] test 6: len=1024 with an ignored second start");
    applyStimulus(0, 1024);
    waitWords("t6a", 500, 600);
    @(posedge clk);
    #1;
    base_addr = AW'(7);
    len       = (AW+1)'(3);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitWords("t6", 1024, 700);
    checkTransfer("t6");
    repeat (10) @(negedge clk);
    checkOutput("t6_no_restart_busy", busy, 0);
    checkOutput("t6_no_extra_words", got_q.size(), 1024);

    $display("[TB] random phase");
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    ready_mode = 2;
    for (int t = 0; t < 4; t++) begin
      int b;
      int n;
      b = (t == 0) ? (DEPTH - 10) : int'($urandom_range(0, DEPTH - 1));
      n = int'($urandom_range(1, 48));
      applyStimulus(b, n);
      waitWords($sformatf("rnd%0d", t), n, 20 * n + 50);
      checkTransfer($sformatf("rnd%0d", t));
    end
    ready_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
